// File: rtl/nv_nvdla_cacc_calc_param.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cacc_calc_param
// Two-stage accumulator calculation slice for the convolution accumulator.
//   S1: sign-extend in_data, add the (optionally masked) previous partial sum,
//       saturate to PSUM_DW.
//   S2: for final beats, arithmetic right shift by the per-beat truncate,
//       round half away from zero, saturate to OUT_DW. This stage is the
//       output register.
// A single advance signal (adv = ~out_valid | out_ready) moves both stages.
// Each stage holds its contents unchanged while stalled.
//
// Optional feature macro: NVDLA_CACC_SAT_CNT_EN
//   Defined   : sat_cnt counts saturation events and saturates at 16'hFFFF.
//               sat_cnt_clr clears the counter, and wins over an increment.
//   Undefined : the sat_cnt_clr port does not exist and sat_cnt is tied to 0.
//
// Ports
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   cfg_truncate  [TRW]     : final right-shift, sampled with each beat
//   in_valid/in_ready       : input handshake (in_ready = adv)
//   in_sel                  : 1 = final beat, 0 = partial beat
//   in_data       [IN_DW]   : signed product sum
//   in_op         [PSUM_DW] : signed previous partial sum
//   in_op_valid             : 0 forces in_op to zero
//   out_valid/out_ready     : output handshake
//   out_is_final            : in_sel of the beat currently on the output
//   out_partial_data/_sat   : partial result (updated by partial beats only)
//   out_final_data/_sat     : final result (updated by final beats only)
//   sat_cnt       [16]      : saturation event count
//   sat_cnt_clr             : counter clear (macro builds only)
// -----------------------------------------------------------------------------
module nv_nvdla_cacc_calc_param #(
    parameter int unsigned IN_DW   = 22,
    parameter int unsigned PSUM_DW = 34,
    parameter int unsigned OUT_DW  = 32,
    parameter int unsigned TRW     = 5
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [TRW-1:0]      cfg_truncate,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sel,
    input  logic [IN_DW-1:0]    in_data,
    input  logic [PSUM_DW-1:0]  in_op,
    input  logic                in_op_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_is_final,
    output logic [PSUM_DW-1:0]  out_partial_data,
    output logic                out_partial_sat,
    output logic [OUT_DW-1:0]   out_final_data,
    output logic                out_final_sat,
    output logic [15:0]         sat_cnt
`ifdef NVDLA_CACC_SAT_CNT_EN
    ,
    input  logic                sat_cnt_clr
`endif
);

    localparam int unsigned SUM_DW = PSUM_DW + 1;
    localparam int unsigned EXT_DW = SUM_DW - IN_DW;
    localparam int unsigned TOP_DW = SUM_DW - OUT_DW + 1;

    logic adv;
    logic accept;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    // ---------------- S1: add + partial saturation ----------------
    logic [SUM_DW-1:0]  sum_c;
    logic               psat_c;
    logic [PSUM_DW-1:0] pres_c;

    always_comb begin
        sum_c  = {{EXT_DW{in_data[IN_DW-1]}}, in_data}
               + (in_op_valid ? {in_op[PSUM_DW-1], in_op} : {SUM_DW{1'b0}});
        // overflow when the guard bit disagrees with the PSUM_DW sign bit
        psat_c = sum_c[SUM_DW-1] ^ sum_c[SUM_DW-2];
        pres_c = sum_c[PSUM_DW-1:0];
        if (psat_c) begin
            pres_c = sum_c[SUM_DW-1] ? {1'b1, {(PSUM_DW-1){1'b0}}}
                                     : {1'b0, {(PSUM_DW-1){1'b1}}};
        end
    end

    logic               s1_valid;
    logic               s1_sel;
    logic [TRW-1:0]     s1_trunc;
    logic [PSUM_DW-1:0] s1_data;
    logic               s1_psat;

    // S1 register; truncate is captured with the beat
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_valid <= 1'b0;
            s1_sel   <= 1'b0;
            s1_trunc <= '0;
            s1_data  <= '0;
            s1_psat  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_sel   <= in_sel;
                s1_trunc <= cfg_truncate;
                s1_data  <= pres_c;
                s1_psat  <= psat_c;
            end
        end
    end

    // ---------------- S2: shift / round / final saturation ----------------
    logic [PSUM_DW-1:0] shifted_c;
    logic [PSUM_DW-1:0] mask_c;
    logic               guide_c;
    logic               sticky_c;
    logic               rnd_c;
    logic [SUM_DW-1:0]  rounded_c;
    logic [TOP_DW-1:0]  top_c;
    logic               fsat_c;
    logic [OUT_DW-1:0]  fres_c;

    always_comb begin
        shifted_c = $signed(s1_data) >>> s1_trunc;
        // mask_c covers every bit shifted out; its top bit is the guide
        mask_c    = (PSUM_DW'(1) << s1_trunc) - PSUM_DW'(1);
        guide_c   = |(s1_data & (mask_c ^ (mask_c >> 1)));
        sticky_c  = |(s1_data & (mask_c >> 1));
        // a floor-shifted negative exact half already sits away from zero
        rnd_c     = guide_c & (~s1_data[PSUM_DW-1] | sticky_c);
        rounded_c = {shifted_c[PSUM_DW-1], shifted_c} + SUM_DW'(rnd_c);
        // fits OUT_DW only if all bits from the OUT_DW sign bit upward agree
        top_c     = rounded_c[SUM_DW-1:OUT_DW-1];
        fsat_c    = ~((&top_c) | ~(|top_c));
        fres_c    = rounded_c[OUT_DW-1:0];
        if (fsat_c) begin
            fres_c = rounded_c[SUM_DW-1] ? {1'b1, {(OUT_DW-1){1'b0}}}
                                         : {1'b0, {(OUT_DW-1){1'b1}}};
        end
    end

    // S2 / output register; only the field group matching the beat updates
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_valid        <= 1'b0;
            out_is_final     <= 1'b0;
            out_partial_data <= '0;
            out_partial_sat  <= 1'b0;
            out_final_data   <= '0;
            out_final_sat    <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_is_final <= s1_sel;
                if (s1_sel) begin
                    out_final_data <= fres_c;
                    out_final_sat  <= fsat_c;
                end else begin
                    out_partial_data <= s1_data;
                    out_partial_sat  <= s1_psat;
                end
            end
        end
    end

`ifdef NVDLA_CACC_SAT_CNT_EN
    logic sat_evt;

    assign sat_evt = out_valid & out_ready
                   & (out_is_final ? out_final_sat : out_partial_sat);

    // saturation event counter, sticks at all-ones
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (sat_evt && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    assign sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_calc_param.sv
module tb_nv_nvdla_cacc_calc_param;

    localparam int unsigned IN_DW   = 22;
    localparam int unsigned PSUM_DW = 34;
    localparam int unsigned OUT_DW  = 32;
    localparam int unsigned TRW     = 5;

    localparam longint P33 = longint'(1) <<< 33;
    localparam longint P31 = longint'(1) <<< 31;

    typedef struct {
        logic        sel;
        longint      d;
        longint      op;
        logic        opv;
        int unsigned t;
        longint      ev;
        logic        es;
    } vec_t;

    typedef struct {
        logic   fin;
        longint pd;
        logic   ps;
        longint fd;
        logic   fs;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [TRW-1:0]     cfg_truncate = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sel = 1'b0;
    logic [IN_DW-1:0]   in_data = '0;
    logic [PSUM_DW-1:0] in_op = '0;
    logic               in_op_valid = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_is_final;
    logic [PSUM_DW-1:0] out_partial_data;
    logic               out_partial_sat;
    logic [OUT_DW-1:0]  out_final_data;
    logic               out_final_sat;
    logic [15:0]        sat_cnt;
    logic               sat_cnt_clr = 1'b0;

    nv_nvdla_cacc_calc_param #(
        .IN_DW(IN_DW), .PSUM_DW(PSUM_DW), .OUT_DW(OUT_DW), .TRW(TRW)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rst_n),
        .cfg_truncate     (cfg_truncate),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_sel           (in_sel),
        .in_data          (in_data),
        .in_op            (in_op),
        .in_op_valid      (in_op_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_is_final     (out_is_final),
        .out_partial_data (out_partial_data),
        .out_partial_sat  (out_partial_sat),
        .out_final_data   (out_final_data),
        .out_final_sat    (out_final_sat),
        .sat_cnt          (sat_cnt)
`ifdef NVDLA_CACC_SAT_CNT_EN
        ,
        .sat_cnt_clr      (sat_cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   q[$];
    longint held_pd = 0, held_fd = 0;
    logic   held_ps = 1'b0, held_fs = 1'b0;
    longint p_v = 0;
    logic   p_s = 1'b0;
    int     cnt_m = 0;
    bit     rnd_rdy = 1'b0;
    bit     saw_stall = 1'b0;
    vec_t   tbl[14];

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // independent reference: clamp, floor-shift with remainder, half away from zero
    function automatic void model(input logic sel, input longint d, input longint op,
                                  input logic opv, input int unsigned t,
                                  output longint v, output logic s);
        longint sum, pmax, pmin, fl, rem, half, omax, omin;
        pmax = P33 - 1;
        pmin = -P33;
        omax = P31 - 1;
        omin = -P31;
        sum  = d + (opv ? op : 0);
        s    = 1'b0;
        if (sum > pmax) begin sum = pmax; s = 1'b1; end
        if (sum < pmin) begin sum = pmin; s = 1'b1; end
        v = sum;
        if (sel) begin
            s   = 1'b0;
            fl  = sum >>> t;
            rem = sum - (fl <<< t);
            if (t > 0) begin
                half = longint'(1) <<< (t - 1);
                if (rem > half || (rem == half && sum >= 0)) fl = fl + 1;
            end
            if (fl > omax) begin fl = omax; s = 1'b1; end
            if (fl < omin) begin fl = omin; s = 1'b1; end
            v = fl;
        end
    endfunction

    function automatic exp_t mk_exp(input logic sel, input longint v, input logic s);
        exp_t e;
        if (sel) begin held_fd = v; held_fs = s; end
        else     begin held_pd = v; held_ps = s; end
        e.fin = sel; e.pd = held_pd; e.ps = held_ps; e.fd = held_fd; e.fs = held_fs;
        return e;
    endfunction

    task automatic cmp_out(input exp_t e, input string tag);
        n_tests++;
        if (out_is_final !== e.fin
            || longint'($signed(out_partial_data)) !== e.pd || out_partial_sat !== e.ps
            || longint'($signed(out_final_data)) !== e.fd || out_final_sat !== e.fs) begin
            n_fail++;
            $display("FAIL %s: actual fin=%0b pd=%0d ps=%0b fd=%0d fs=%0b required fin=%0b pd=%0d ps=%0b fd=%0d fs=%0b",
                     tag, out_is_final, $signed(out_partial_data), out_partial_sat,
                     $signed(out_final_data), out_final_sat, e.fin, e.pd, e.ps, e.fd, e.fs);
        end
    endtask

    // one clock: observe at negedge, return #1 after the posedge
    task automatic step(output bit acc);
        exp_t e;
        if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && !out_ready && !in_ready) saw_stall = 1'b1;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("stale_beat", 1, 0);
            end else begin
                e = q[0];
                cmp_out(e, out_ready ? "beat" : "stall_hold");
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.fin ? e.fs : e.ps) cnt_m = (cnt_m == 65535) ? cnt_m : cnt_m + 1;
                end
            end
        end
        if (acc) q.push_back(mk_exp(in_sel, p_v, p_s));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic sel, input longint d, input longint op,
                          input logic opv, input int unsigned t,
                          input longint ev, input logic es);
        in_valid     = 1'b1;
        in_sel       = sel;
        in_data      = IN_DW'(d);
        in_op        = PSUM_DW'(op);
        in_op_valid  = opv;
        cfg_truncate = TRW'(t);
        p_v          = ev;
        p_s          = es;
    endtask

    task automatic send(input logic sel, input longint d, input longint op,
                        input logic opv, input int unsigned t,
                        input longint ev, input logic es);
        bit acc;
        int c;
        set_in(sel, d, op, opv, t, ev, es);
        acc = 1'b0;
        c = 0;
        while (!acc && c < 40) begin
            step(acc);
            c++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        int c;
        in_valid = 1'b0;
        rnd_rdy  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while ((q.size() != 0 || out_valid) && c < 40) begin
            step(acc);
            c++;
        end
        check("drain_empty", longint'(q.size()), 0);
    endtask

    task automatic chk_cnt(input string name);
`ifdef NVDLA_CACC_SAT_CNT_EN
        check(name, longint'(sat_cnt), longint'(cnt_m));
`else
        check(name, longint'(sat_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_sat_cnt", longint'(sat_cnt), 0);
        check("rst_pdata", longint'(out_partial_data), 0);
        check("rst_fdata", longint'(out_final_data), 0);
        q.delete();
        held_pd = 0; held_ps = 1'b0; held_fd = 0; held_fs = 1'b0;
        cnt_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        longint v, d, op;
        logic s, sel, opv;
        int unsigned t;

        tbl[0]  = '{1'b0, 5,        -3,      1'b1, 0,  2,          1'b0};
        tbl[1]  = '{1'b0, 1,        P33-1,   1'b1, 0,  P33-1,      1'b1};
        tbl[2]  = '{1'b1, 0,        5,       1'b1, 1,  3,          1'b0};
        tbl[3]  = '{1'b1, 0,        -5,      1'b1, 1,  -3,         1'b0};
        tbl[4]  = '{1'b1, 0,        -3,      1'b1, 2,  -1,         1'b0};
        tbl[5]  = '{1'b1, 0,        1<<19,   1'b1, 20, 1,          1'b0};
        tbl[6]  = '{1'b1, 0,        P33-1,   1'b1, 0,  P31-1,      1'b1};
        tbl[7]  = '{1'b1, 0,        -P33,    1'b1, 0,  -P31,       1'b1};
        tbl[8]  = '{1'b0, -1,       -P33,    1'b1, 0,  -P33,       1'b1};
        tbl[9]  = '{1'b0, 100,      999,     1'b0, 0,  100,        1'b0};
        tbl[10] = '{1'b1, 0,        P33-1,   1'b1, 31, 4,          1'b0};
        tbl[11] = '{1'b1, -8,       0,       1'b1, 4,  -1,         1'b0};
        tbl[12] = '{1'b1, 12,       0,       1'b1, 3,  2,          1'b0};
        tbl[13] = '{1'b0, -2097152, 0,       1'b1, 7,  -2097152,   1'b0};

        do_reset();
        chk_cnt("cnt_after_reset");

        // latency: first beat alone
        out_ready = 1'b1;
        set_in(tbl[0].sel, tbl[0].d, tbl[0].op, tbl[0].opv, tbl[0].t, tbl[0].ev, tbl[0].es);
        step(acc);
        check("lat_accept", longint'(acc), 1);
        in_valid = 1'b0;
        check("lat_cycle1_valid", longint'(out_valid), 0);
        step(acc);
        check("lat_cycle2_valid", longint'(out_valid), 1);
        drain();

        // overflow beat then the sat counter
        send(tbl[1].sel, tbl[1].d, tbl[1].op, tbl[1].opv, tbl[1].t, tbl[1].ev, tbl[1].es);
        drain();
        chk_cnt("cnt_after_psat");

        // whole table back to back, truncate changing every beat
        for (int i = 0; i < 14; i++)
            send(tbl[i].sel, tbl[i].d, tbl[i].op, tbl[i].opv, tbl[i].t, tbl[i].ev, tbl[i].es);
        drain();
        chk_cnt("cnt_after_table");

        // backpressure: 4 beats, out_ready low for 3 cycles
        saw_stall = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            out_ready = (c >= 3);
            set_in(1'b0, longint'(k + 1), 0, 1'b0, 0, longint'(k + 1), 1'b0);
            step(acc);
            if (acc) k++;
        end
        check("bp_all_accepted", longint'(k), 4);
        check("bp_in_ready_dropped", longint'(saw_stall), 1);
        drain();

`ifdef NVDLA_CACC_SAT_CNT_EN
        sat_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_cnt_clr = 1'b0;
        cnt_m = 0;
        chk_cnt("cnt_clear");
`endif

        // random stream under random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel = 1'($urandom);
            opv = ($urandom_range(7) != 0);
            t   = $urandom_range(31);
            d   = longint'($signed(IN_DW'($urandom)));
            case ($urandom_range(5))
                0:       op = P33 - 1;
                1:       op = -P33;
                2:       op = longint'($signed(8'($urandom)));
                default: op = longint'($signed(PSUM_DW'({$urandom, $urandom})));
            endcase
            model(sel, d, op, opv, t, v, s);
            send(sel, d, op, opv, t, v, s);
        end
        drain();
        chk_cnt("cnt_after_random");

        // reset with two beats in flight
        out_ready = 1'b1;
        send(1'b0, 7, 0, 1'b0, 0, 7, 1'b0);
        send(1'b0, 8, 0, 1'b0, 0, 8, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(acc);
            check("post_rst_no_valid", longint'(out_valid), 0);
        end
        chk_cnt("cnt_after_midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
